layer_feeder: RTL and testbench
===============================

Name: layer_feeder

Overview:
- Source end of the layer pixel stream: drives myInput/ce, plus the packed weight and bias buses, into a layer instance.
- Accepts a serial load of kernel weights, bias and one INPUT_SIZE x INPUT_SIZE feature map through a valid/ready port, storing them in internal registers/RAM.
- On start, bursts pixels row-major with ce high, then holds ce high to flush the layer pipeline until the layer's end_op returns.
- Sits between the host/DMA load path and layer.

Parameters:
- DATA_WIDTH, 16, word width of pixels, weights and bias.
- INPUT_SIZE, 28, feature map side length; N = INPUT_SIZE*INPUT_SIZE pixels.
- KERNEL_SIZE, 5, kernel side length; K2 = KERNEL_SIZE*KERNEL_SIZE weights.
- DRAIN_MAX, 1024, maximum DRAIN cycles waiting for layer_end_op before abort.

Ports:
- clk  input  1  clock, rising edge.
- global_rst  input  1  asynchronous, active-low reset.
- ld_valid  input  1  load word valid.
- ld_data  input  DATA_WIDTH  load word.
- ld_ready  output  1  feeder accepts a load word this cycle.
- start  input  1  request a stream burst.
- layer_end_op  input  1  end_op from the downstream layer.
- myInput  output  DATA_WIDTH  pixel to layer.
- ce  output  1  clock enable to layer.
- weight  output  K2*DATA_WIDTH  packed kernel to layer.
- bias  output  DATA_WIDTH  bias to layer.
- busy  output  1  high in STREAM and DRAIN.
- done  output  1  one-cycle pulse at successful end of frame.
- err  output  1  sticky drain-timeout flag; cleared on reset or accepted start.

Behaviour:
- Reset (global_rst=0, async): state LOAD, load counter 0, myInput=0, ce=0, weight=0, bias=0, busy=0, done=0, err=0. ld_ready=1 once reset releases. Pixel RAM contents are not cleared.
- LOAD: ld_ready=1. A word transfers on a rising edge with ld_valid&&ld_ready.
  - Word k < K2 goes to weight[k*DATA_WIDTH +: DATA_WIDTH].
  - Word K2 goes to bias.
  - Words K2+1 .. K2+N go to pixel address 0..N-1, row-major.
  - After word K2+N transfers, state becomes READY on the same edge.
- READY: ld_ready=0, ld_valid ignored. start sampled high moves the state to STREAM and clears err. start is ignored in every other state, including the cycle of the last load word.
- STREAM:
  - Latency: ce rises in the first cycle after the edge that sampled start.
  - Burst length: ce is high for exactly N consecutive cycles, with myInput = pixel[i] in burst cycle i (registered outputs, no bubbles).
  - Exit: after pixel N-1, enter DRAIN.
- DRAIN:
  - Outputs: ce stays 1, myInput=0 (flush).
  - layer_end_op sampled high: next cycle ce=0, done=1 for one cycle, state LOAD with counter 0.
  - Timeout: a drain cycle counter reaching DRAIN_MAX gives ce=0, err=1, no done, state LOAD.
- layer_end_op is ignored outside DRAIN.
- weight and bias hold stable from load through STREAM/DRAIN. They change only on LOAD writes of the corresponding word.
- Reset mid-STREAM/DRAIN: outputs go to reset values immediately; no done.
- Address and counter widths: $clog2 of their range. Counters must not wrap within a frame.

Optional Feature:
- Macro: LAYER_FEEDER_PAUSE_EN.
- When defined:
  - Adds input port pause (1 bit).
  - While pause=1 in STREAM or DRAIN: ce=0, myInput holds its value, the pixel index and drain counter freeze, and the DRAIN_MAX timer does not advance.
  - Resumes with the next pixel in the cycle after pause falls.
  - pause is ignored in LOAD/READY.
- When undefined: no pause port; ce is never interrupted within a burst.

Test Plan (DATA_WIDTH=8, INPUT_SIZE=6, KERNEL_SIZE=3, DRAIN_MAX=16; 46 load words):
- Load words 1..9, bias 0x80, pixels 0x00..0x23 -> weight[7:0]=0x01, weight[71:64]=0x09, bias=0x80, state READY, ld_ready=0.
- start one cycle in READY -> ce high 36 consecutive cycles starting the cycle after start sampled, myInput=0x00..0x23 in order, busy=1.
- In DRAIN, pulse layer_end_op after 5 cycles -> ce low next cycle, done high exactly 1 cycle, ld_ready=1, err=0.
- Never assert layer_end_op -> after 16 DRAIN cycles ce=0, err=1, no done; next accepted start clears err.
- start asserted during LOAD and with the 46th word; ld_valid toggled during STREAM -> both ignored, no state change, RAM unchanged.
- global_rst low at burst pixel 10 -> ce=0, myInput=0, weight=0, busy=0 asynchronously. After release, ld_ready=1 and a full reload plus start streams correctly. With LAYER_FEEDER_PAUSE_EN, pause for 3 cycles at pixel 5 -> ce low 3 cycles, pixel 5 presented on resume.

Source files
------------

// File: rtl/layer_feeder.sv
// Source end of the layer pixel stream: serially loads kernel, bias and one feature map, then
// bursts pixels with ce high and flushes until end_op. Optional pause: LAYER_FEEDER_PAUSE_EN.
module layer_feeder #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned INPUT_SIZE  = 28,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned DRAIN_MAX   = 1024
) (
  input  logic                                      clk,
  input  logic                                      global_rst,
  input  logic                                      ld_valid,
  input  logic [DATA_WIDTH-1:0]                     ld_data,
  output logic                                      ld_ready,
  input  logic                                      start,
  input  logic                                      layer_end_op,
`ifdef LAYER_FEEDER_PAUSE_EN
  input  logic                                      pause,
`endif
  output logic [DATA_WIDTH-1:0]                     myInput,
  output logic                                      ce,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weight,
  output logic [DATA_WIDTH-1:0]                     bias,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err
);

  localparam int unsigned N         = INPUT_SIZE * INPUT_SIZE;
  localparam int unsigned K2        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned LastWord  = K2 + N;
  localparam int unsigned LCW       = $clog2(LastWord + 1);
  localparam int unsigned AW        = $clog2(N);
  localparam int unsigned PIW       = $clog2(N + 1);
  localparam int unsigned DCW       = $clog2(DRAIN_MAX + 1);

  localparam logic [1:0] StLoad   = 2'd0;
  localparam logic [1:0] StReady  = 2'd1;
  localparam logic [1:0] StStream = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [LCW-1:0]           ld_cnt_q, ld_cnt_d;
  logic [PIW-1:0]           pix_idx_q, pix_idx_d;
  logic [DCW-1:0]           drain_q, drain_d;
  logic [DATA_WIDTH-1:0]    myin_q, myin_d;
  logic                     ce_q, ce_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [K2*DATA_WIDTH-1:0] weight_q, weight_d;
  logic [DATA_WIDTH-1:0]    bias_q, bias_d;
  logic                     mem_we;
  logic [AW-1:0]            mem_waddr;
  logic                     pause_act;

  // Pixel store is plain storage: never reset, written only during LOAD.
  logic [DATA_WIDTH-1:0]    mem_q [N];

`ifdef LAYER_FEEDER_PAUSE_EN
  assign pause_act = pause;
`else
  assign pause_act = 1'b0;
`endif

  assign mem_waddr = AW'(ld_cnt_q - LCW'(K2 + 1));

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    pix_idx_d = pix_idx_q;
    drain_d   = drain_q;
    myin_d    = myin_q;
    ce_d      = ce_q;
    done_d    = 1'b0;
    err_d     = err_q;
    weight_d  = weight_q;
    bias_d    = bias_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (ld_valid) begin
          for (int unsigned k = 0; k < K2; k++) begin
            if (ld_cnt_q == LCW'(k)) weight_d[k*DATA_WIDTH +: DATA_WIDTH] = ld_data;
          end
          if (ld_cnt_q == LCW'(K2)) bias_d = ld_data;
          mem_we = (ld_cnt_q > LCW'(K2));
          if (ld_cnt_q == LCW'(LastWord)) begin
            state_d  = StReady;
            ld_cnt_d = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
      StReady: begin
        if (start) begin
          state_d   = StStream;
          err_d     = 1'b0;
          ce_d      = 1'b1;
          myin_d    = mem_q[0];
          pix_idx_d = PIW'(1);
        end
      end
      StStream: begin
        if (pause_act) begin
          ce_d = 1'b0;
        end else if (pix_idx_q == PIW'(N)) begin
          state_d = StDrain;
          myin_d  = '0;
          ce_d    = 1'b1;
          drain_d = '0;
        end else begin
          myin_d    = mem_q[AW'(pix_idx_q)];
          ce_d      = 1'b1;
          pix_idx_d = pix_idx_q + 1'b1;
        end
      end
      StDrain: begin
        if (pause_act) begin
          ce_d = 1'b0;
        end else if (layer_end_op) begin
          ce_d     = 1'b0;
          done_d   = 1'b1;
          state_d  = StLoad;
          ld_cnt_d = '0;
        end else if (drain_q == DCW'(DRAIN_MAX - 1)) begin
          ce_d     = 1'b0;
          err_d    = 1'b1;
          state_d  = StLoad;
          ld_cnt_d = '0;
        end else begin
          ce_d    = 1'b1;
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      state_q   <= StLoad;
      ld_cnt_q  <= '0;
      pix_idx_q <= '0;
      drain_q   <= '0;
      myin_q    <= '0;
      ce_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      weight_q  <= '0;
      bias_q    <= '0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      pix_idx_q <= pix_idx_d;
      drain_q   <= drain_d;
      myin_q    <= myin_d;
      ce_q      <= ce_d;
      done_q    <= done_d;
      err_q     <= err_d;
      weight_q  <= weight_d;
      bias_q    <= bias_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= ld_data;
  end

  assign ld_ready = (state_q == StLoad);
  assign busy     = (state_q == StStream) || (state_q == StDrain);
  assign myInput  = myin_q;
  assign ce       = ce_q;
  assign weight   = weight_q;
  assign bias     = bias_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_layer_feeder.sv
// Scoreboard bench for layer_feeder: pixels queued at load time, popped as the burst appears.
module tb_layer_feeder;
  localparam int DW = 8;
  localparam int IS = 6;
  localparam int KS = 3;
  localparam int DM = 16;
  localparam int N  = IS * IS;
  localparam int K2 = KS * KS;

  logic              clk = 1'b0;
  logic              global_rst = 1'b0;
  logic              ld_valid = 1'b0;
  logic [DW-1:0]     ld_data = '0;
  logic              start = 1'b0;
  logic              layer_end_op = 1'b0;
  logic              ld_ready, ce, busy, done, err;
  logic [DW-1:0]     myInput, bias;
  logic [K2*DW-1:0]  weight;
`ifdef LAYER_FEEDER_PAUSE_EN
  logic              pause = 1'b0;
`endif

  layer_feeder #(
    .DATA_WIDTH(DW), .INPUT_SIZE(IS), .KERNEL_SIZE(KS), .DRAIN_MAX(DM)
  ) dut (
    .clk(clk), .global_rst(global_rst), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .start(start), .layer_end_op(layer_end_op),
`ifdef LAYER_FEEDER_PAUSE_EN
    .pause(pause),
`endif
    .myInput(myInput), .ce(ce), .weight(weight), .bias(bias), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0]    sb_q[$];
  logic [K2*DW-1:0] exp_w = '0;
  logic [DW-1:0]    exp_b = '0;

  task automatic check_val(input string tag, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic load_frame(input logic [7:0] wbase, input logic [7:0] b,
                            input logic [7:0] pbase, input bit hold_start);
    start = hold_start;
    for (int k = 0; k < K2 + 1 + N; k++) begin
      @(negedge clk);
      if (k % 7 == 3) begin
        ld_valid = 1'b0;
        @(negedge clk);
      end
      ld_valid = 1'b1;
      if (k < K2) begin
        ld_data = DW'(wbase + k);
        exp_w[k*DW +: DW] = ld_data;
      end else if (k == K2) begin
        ld_data = b;
        exp_b = b;
      end else begin
        ld_data = DW'(pbase + (k - K2 - 1));
        sb_q.push_back(ld_data);
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
    start = 1'b0;
    check_val("ld_ready_low", ld_ready, 0);
    check_val("ready_not_busy", busy, 0);
    check_val("weight_loaded", weight, exp_w);
    check_val("bias_loaded", bias, exp_b);
    @(negedge clk);
    check_val("late_start_ignored", busy, 0);
    check_val("ready_ce_low", ce, 0);
  endtask

  // endop_at < 0 means never assert layer_end_op and expect the drain timeout.
  task automatic run_frame(input int endop_at, input bit toggle_ld);
    logic [DW-1:0] exp_px;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      exp_px = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      check_val("burst_ce", ce, 1);
      check_val("burst_pixel", myInput, exp_px);
      check_val("burst_busy", busy, 1);
      if (i == 0) check_val("err_cleared", err, 0);
      layer_end_op = (i == 2);
      ld_valid = toggle_ld && i[0];
      ld_data = 8'hff;
    end
    if (endop_at >= 0) begin
      for (int d = 0; d < endop_at; d++) begin
        @(negedge clk);
        ld_valid = 1'b0;
        check_val("drain_ce", ce, 1);
        check_val("drain_flush", myInput, 0);
      end
      layer_end_op = 1'b1;
      @(negedge clk);
      layer_end_op = 1'b0;
      check_val("end_ce_low", ce, 0);
      check_val("end_done", done, 1);
      check_val("end_ld_ready", ld_ready, 1);
      check_val("end_err", err, 0);
      check_val("end_busy", busy, 0);
      check_val("weight_hold", weight, exp_w);
      @(negedge clk);
      check_val("done_one_cycle", done, 0);
    end else begin
      for (int d = 0; d < DM; d++) begin
        @(negedge clk);
        ld_valid = 1'b0;
        check_val("to_drain_ce", ce, 1);
      end
      @(negedge clk);
      check_val("to_ce_low", ce, 0);
      check_val("to_err", err, 1);
      check_val("to_no_done", done, 0);
      check_val("to_ld_ready", ld_ready, 1);
      check_val("to_bias_hold", bias, exp_b);
    end
  endtask

  initial begin
    logic [DW-1:0] exp_px;
    #3;
    check_val("rst_ce", ce, 0);
    check_val("rst_myInput", myInput, 0);
    check_val("rst_weight", weight, 0);
    check_val("rst_bias", bias, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    @(negedge clk);
    global_rst = 1'b1;
    @(negedge clk);
    check_val("rst_ld_ready", ld_ready, 1);

    load_frame(8'h01, 8'h80, 8'h00, 1'b1);
    check_val("w_first", weight[7:0], 8'h01);
    check_val("w_last", weight[71:64], 8'h09);
    run_frame(5, 1'b1);

    load_frame(8'h11, 8'h7f, 8'h40, 1'b0);
    run_frame(-1, 1'b0);

    load_frame(8'h21, 8'h55, 8'h90, 1'b0);
    run_frame(3, 1'b0);

    load_frame(8'h31, 8'h33, 8'ha0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge clk);
      exp_px = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      check_val("pre_rst_pixel", myInput, exp_px);
    end
    #2 global_rst = 1'b0;
    #1;
    check_val("mid_rst_ce", ce, 0);
    check_val("mid_rst_myInput", myInput, 0);
    check_val("mid_rst_weight", weight, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_done", done, 0);
    sb_q.delete();
    @(negedge clk);
    global_rst = 1'b1;
    @(negedge clk);
    check_val("post_rst_ld_ready", ld_ready, 1);
    check_val("post_rst_done", done, 0);

    load_frame(8'h41, 8'h22, 8'hc0, 1'b0);
    run_frame(7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
